// File: rtl/clk_ratio_monitor_pkg.sv
// -----------------------------------------------------------------------------
// clk_ratio_monitor_pkg
// Shared clock-system definitions for the divided-clock ratio monitor.
//   - mon_state_t          : monitor FSM states (IDLE / ARM / MEASURE)
//   - RATIO_WIDTH_DEFAULT  : default width of the ratio / high-time counters
//   - CNT_MAX_DEFAULT      : largest period measurable at the default width
//   - cnt_max()            : largest period measurable for a given width
// -----------------------------------------------------------------------------
package clk_ratio_monitor_pkg;

   localparam int RATIO_WIDTH_DEFAULT = 6;

   function automatic int cnt_max(input int width);
      return (1 << width) - 1;
   endfunction

   localparam int CNT_MAX_DEFAULT = cnt_max(RATIO_WIDTH_DEFAULT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } mon_state_t;

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Two-flop synchronizer for a single asynchronous level into the i_clk domain.
// Both flops clear to 0 on reset.
// Ports:
//   i_clk    in   destination clock (rising edge)
//   i_rst_n  in   asynchronous active-low reset
//   i_d      in   asynchronous input level
//   o_q      out  synchronized level, 2 i_clk cycles of latency
// -----------------------------------------------------------------------------
module bit_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic meta_p0;
   logic sync_p1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         // metastability catch flop
         meta_p0 <= i_d;
         // resolved output flop
         sync_p1 <= meta_p0;
      end
   end

   assign o_q = sync_p1;

endmodule

// File: rtl/clk_ratio_monitor.sv
// -----------------------------------------------------------------------------
// clk_ratio_monitor
// Measures the period and high time of a divided clock (i_div_clk) in
// i_ref_clk cycles, reports each completed period, and asserts lock once
// LOCK_COUNT consecutive identical periods have been seen. A clock that
// stalls for 2^RATIO_WIDTH-1 cycles raises a one-cycle error pulse.
// Ports:
//   i_ref_clk   in   reference clock; every flop runs on its rising edge
//   i_rst_n     in   asynchronous active-low reset
//   i_meas_en   in   measurement enable; low returns the monitor to IDLE
//   i_div_clk   in   clock under measurement, sampled as an async level
//   o_ratio     out  last measured period (i_ref_clk cycles)
//   o_high_cnt  out  last measured high time (i_ref_clk cycles)
//   o_valid     out  one-cycle pulse when o_ratio / o_high_cnt update
//   o_locked    out  LOCK_COUNT consecutive equal periods observed
//   o_err       out  one-cycle pulse on a stalled clock (timeout)
// -----------------------------------------------------------------------------
module clk_ratio_monitor
   import clk_ratio_monitor_pkg::*;
#(
   parameter int RATIO_WIDTH = RATIO_WIDTH_DEFAULT,
   parameter int LOCK_COUNT  = 4
) (
   input  logic                   i_ref_clk,
   input  logic                   i_rst_n,
   input  logic                   i_meas_en,
   input  logic                   i_div_clk,
   output logic [RATIO_WIDTH-1:0] o_ratio,
   output logic [RATIO_WIDTH-1:0] o_high_cnt,
   output logic                   o_valid,
   output logic                   o_locked,
   output logic                   o_err
);

   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

   localparam logic [RATIO_WIDTH-1:0] CNT_MAX    = RATIO_WIDTH'(cnt_max(RATIO_WIDTH));
   localparam logic [RATIO_WIDTH-1:0] CNT_ONE    = RATIO_WIDTH'(1);
   localparam logic [MATCH_W-1:0]     MATCH_FULL = MATCH_W'(LOCK_COUNT);
   localparam logic [MATCH_W-1:0]     MATCH_ONE  = MATCH_W'(1);

   // Saturating increment of the consecutive-match counter.
   function automatic logic [MATCH_W-1:0] sat_inc_match(input logic [MATCH_W-1:0] v);
      if (v >= MATCH_FULL) begin
         return MATCH_FULL;
      end
      return v + MATCH_ONE;
   endfunction

   mon_state_t               state;
   mon_state_t               state_nxt;

   logic                     div_sync_p0;
   logic                     div_sync_p1;
   logic                     div_edge;

   logic [RATIO_WIDTH-1:0]   cnt;
   logic [RATIO_WIDTH-1:0]   hi_cnt;
   logic [RATIO_WIDTH-1:0]   prev_ratio;
   logic [MATCH_W-1:0]       match_cnt;
   logic [MATCH_W-1:0]       match_nxt;

   logic                     do_clear;
   logic                     do_arm;
   logic                     do_capture;
   logic                     do_timeout;
   logic                     do_count;

   // ---- stage 0: synchronize the divided clock ----
   bit_sync u_div_sync (
      .i_clk   (i_ref_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_div_clk),
      .o_q     (div_sync_p0)
   );

   // ---- stage 1: rising-edge detect on the synchronized level ----
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_sync_p1 <= 1'b0;
      end else begin
         div_sync_p1 <= div_sync_p0;
      end
   end

   assign div_edge = div_sync_p0 & ~div_sync_p1;

   // ---- stage 2: FSM, counters, capture and lock ----
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      do_clear   = 1'b0;
      do_arm     = 1'b0;
      do_capture = 1'b0;
      do_timeout = 1'b0;
      do_count   = 1'b0;
      if (!i_meas_en) begin
         state_nxt = IDLE;
         do_clear  = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = ARM;
               do_clear  = 1'b1;
            end
            ARM: begin
               if (div_edge) begin
                  state_nxt = MEASURE;
                  do_arm    = 1'b1;
               end
            end
            MEASURE: begin
               // An edge on the last countable cycle is still a valid period.
               if (div_edge) begin
                  do_capture = 1'b1;
               end else if (cnt == CNT_MAX) begin
                  do_timeout = 1'b1;
                  state_nxt  = ARM;
               end else begin
                  do_count = 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               do_clear  = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      if ((match_cnt != '0) && (cnt == prev_ratio)) begin
         match_nxt = sat_inc_match(match_cnt);
      end else begin
         match_nxt = MATCH_ONE;
      end
   end

   // The edge cycle itself is the first high cycle of the new period, so
   // both counters restart at 1 on an edge; the high count then covers
   // exactly the same window of cycles as the period count.
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt        <= '0;
         hi_cnt     <= '0;
         prev_ratio <= '0;
         match_cnt  <= '0;
         o_ratio    <= '0;
         o_high_cnt <= '0;
         o_valid    <= 1'b0;
         o_locked   <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         o_valid <= do_capture;
         o_err   <= do_timeout;
         if (do_clear) begin
            cnt       <= '0;
            hi_cnt    <= '0;
            match_cnt <= '0;
            o_locked  <= 1'b0;
         end else if (do_arm) begin
            cnt    <= CNT_ONE;
            hi_cnt <= CNT_ONE;
         end else if (do_capture) begin
            o_ratio    <= cnt;
            o_high_cnt <= hi_cnt;
            prev_ratio <= cnt;
            match_cnt  <= match_nxt;
            o_locked   <= (match_nxt == MATCH_FULL);
            cnt        <= CNT_ONE;
            hi_cnt     <= CNT_ONE;
         end else if (do_timeout) begin
            cnt       <= '0;
            hi_cnt    <= '0;
            match_cnt <= '0;
            o_locked  <= 1'b0;
         end else if (do_count) begin
            cnt    <= cnt + CNT_ONE;
            hi_cnt <= hi_cnt + RATIO_WIDTH'(div_sync_p0);
         end
      end
   end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_ratio_monitor
// Drives i_div_clk / i_meas_en from precomputed per-cycle waveforms. A
// reference model derives every expected output from the list of divided
// clock rising edges and the enable windows, then each cycle's outputs are
// compared against it.
// -----------------------------------------------------------------------------
module tb_clk_ratio_monitor;

   localparam int RW   = 6;
   localparam int LC   = 4;
   localparam int MAXP = (1 << RW) - 1;
   localparam int MAXN = 4096;
   localparam int SYNC_LAT = 2;   // drive cycle of a rise -> cycle the edge is seen

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          en    = 1'b0;
   logic          divc  = 1'b0;
   logic [RW-1:0] ratio;
   logic [RW-1:0] high;
   logic          valid;
   logic          locked;
   logic          err;

   clk_ratio_monitor #(
      .RATIO_WIDTH (RW),
      .LOCK_COUNT  (LC)
   ) dut (
      .i_ref_clk  (clk),
      .i_rst_n    (rst_n),
      .i_meas_en  (en),
      .i_div_clk  (divc),
      .o_ratio    (ratio),
      .o_high_cnt (high),
      .o_valid    (valid),
      .o_locked   (locked),
      .o_err      (err)
   );

   always #5 clk = ~clk;

   int div_w [MAXN];
   int en_w  [MAXN];
   int wlen;

   int ev_v [MAXN];
   int ev_r [MAXN];
   int ev_h [MAXN];
   int ev_e [MAXN];
   int ev_ls[MAXN];
   int ev_lv[MAXN];

   int e_valid [MAXN];
   int e_err   [MAXN];
   int e_locked[MAXN];
   int e_ratio [MAXN];
   int e_high  [MAXN];

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, act, exp);
      end
   endtask

   // ---------------- waveform construction ----------------
   task automatic clear_wave();
      wlen = 0;
      for (int i = 0; i < MAXN; i++) begin
         div_w[i] = 0;
         en_w[i]  = 0;
      end
   endtask

   task automatic add_seg(input int h, input int l);
      for (int i = 0; i < h + l; i++) begin
         if (wlen < MAXN) begin
            div_w[wlen] = (i < h) ? 1 : 0;
            wlen++;
         end
      end
   endtask

   task automatic en_range(input int a, input int b);
      for (int i = a; i < b && i < MAXN; i++) en_w[i] = 1;
   endtask

   // ---------------- reference model ----------------
   function automatic void mark_lock(input int n, input int v);
      if (n < wlen) begin
         ev_ls[n] = 1;
         ev_lv[n] = v;
      end
   endfunction

   function automatic void mark_err(input int n);
      if (n < wlen) ev_e[n] = 1;
      mark_lock(n, 0);
   endfunction

   // One enable window: en high on drive cycles c0 .. c1-1.
   function automatic void model_window(input int c0, input int c1);
      int last, lastr, m, prev, gap, hsum, d;
      last = -1; lastr = -1; m = 0; prev = 0;
      if (c1 < wlen) mark_lock(c1 + 1, 0);
      for (int r = 0; r < wlen; r++) begin
         if (div_w[r] == 1 && (r == 0 || div_w[r-1] == 0)) begin
            d = r + SYNC_LAT;
            if (d >= c0 + 1 && d <= c1 - 1) begin
               if (last < 0) begin
                  last = d; lastr = r;
               end else begin
                  gap = d - last;
                  if (gap <= MAXP) begin
                     hsum = 0;
                     for (int k = lastr; k < r; k++) hsum += div_w[k];
                     if (d + 1 < wlen) begin
                        ev_v[d+1] = 1;
                        ev_r[d+1] = gap;
                        ev_h[d+1] = hsum;
                     end
                     m = (m > 0 && gap == prev) ? ((m + 1 > LC) ? LC : m + 1) : 1;
                     prev = gap;
                     mark_lock(d + 1, (m == LC) ? 1 : 0);
                  end else begin
                     mark_err(last + MAXP + 1);
                     m = 0;
                  end
                  last = d; lastr = r;
               end
            end
         end
      end
      if (last >= 0 && last + MAXP <= c1 - 1) mark_err(last + MAXP + 1);
   endfunction

   task automatic build_model();
      int n, c1, cr, ch, cl;
      for (int i = 0; i < MAXN; i++) begin
         ev_v[i] = 0; ev_r[i] = 0; ev_h[i] = 0; ev_e[i] = 0; ev_ls[i] = 0; ev_lv[i] = 0;
      end
      n = 0;
      while (n < wlen) begin
         if (en_w[n] == 1 && (n == 0 || en_w[n-1] == 0)) begin
            c1 = n;
            while (c1 < wlen && en_w[c1] == 1) c1++;
            model_window(n, c1);
            n = c1;
         end else begin
            n++;
         end
      end
      cr = 0; ch = 0; cl = 0;
      for (int i = 0; i < wlen; i++) begin
         if (ev_v[i] != 0) begin
            cr = ev_r[i];
            ch = ev_h[i];
         end
         if (ev_ls[i] != 0) cl = ev_lv[i];
         e_valid[i]  = ev_v[i];
         e_err[i]    = ev_e[i];
         e_locked[i] = cl;
         e_ratio[i]  = cr;
         e_high[i]   = ch;
      end
   endtask

   // ---------------- drive and check ----------------
   task automatic do_reset();
      rst_n = 1'b0;
      divc  = 1'b0;
      en    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_scenario(input int abort_at);
      for (int n = 0; n < wlen; n++) begin
         @(posedge clk);
         #1;
         divc = (div_w[n] != 0);
         en   = (en_w[n] != 0);
         @(negedge clk);
         cyc = n;
         check_val("valid",  32'(valid),  32'(e_valid[n]));
         check_val("err",    32'(err),    32'(e_err[n]));
         check_val("locked", 32'(locked), 32'(e_locked[n]));
         check_val("ratio",  32'(ratio),  32'(e_ratio[n]));
         check_val("high",   32'(high),   32'(e_high[n]));
         if (n == abort_at) begin
            #1;
            rst_n = 1'b0;
            #1;
            check_val("rst_ratio",  32'(ratio),  32'd0);
            check_val("rst_high",   32'(high),   32'd0);
            check_val("rst_valid",  32'(valid),  32'd0);
            check_val("rst_locked", 32'(locked), 32'd0);
            check_val("rst_err",    32'(err),    32'd0);
            divc = 1'b0;
            en   = 1'b0;
            break;
         end
      end
   endtask

   initial begin
      int p, h, reps;
      do_reset();

      // ratio 8 -> 6 -> 8 with a disable window while locked
      clear_wave();
      add_seg(0, 5);
      repeat (10) add_seg(4, 4);
      repeat (8)  add_seg(3, 3);
      repeat (8)  add_seg(4, 4);
      add_seg(0, 10);
      en_range(3, 120);
      en_range(130, wlen);
      build_model();
      run_scenario(-1);

      // odd ratio 5 with changing duty (period constant, lock holds)
      do_reset();
      clear_wave();
      add_seg(0, 4);
      repeat (8) add_seg(3, 2);
      repeat (6) add_seg(2, 3);
      add_seg(0, 6);
      en_range(1, wlen);
      build_model();
      run_scenario(-1);

      // stall -> timeout, resume, max period 63, min period 2, period 64
      do_reset();
      clear_wave();
      add_seg(0, 4);
      repeat (6) add_seg(4, 4);
      add_seg(0, 100);
      repeat (6) add_seg(4, 4);
      repeat (5) add_seg(32, 31);
      repeat (6) add_seg(1, 1);
      repeat (3) add_seg(30, 34);
      add_seg(0, 90);
      en_range(2, wlen);
      build_model();
      run_scenario(-1);

      // randomized periods, duties, stalls and enable windows
      do_reset();
      clear_wave();
      add_seg(0, 4);
      while (wlen < 3000) begin
         if ($urandom_range(0, 9) == 0) begin
            add_seg(0, int'($urandom_range(50, 120)));
         end else begin
            p    = int'($urandom_range(2, MAXP));
            h    = int'($urandom_range(1, p - 1));
            reps = int'($urandom_range(1, 7));
            repeat (reps) add_seg(h, p - h);
         end
      end
      begin
         int pos;
         pos = int'($urandom_range(0, 10));
         while (pos < wlen) begin
            int on_len;
            on_len = int'($urandom_range(100, 600));
            en_range(pos, pos + on_len);
            pos = pos + on_len + int'($urandom_range(1, 20));
         end
      end
      build_model();
      run_scenario(-1);

      // reset asserted mid-period while locked
      do_reset();
      clear_wave();
      add_seg(0, 4);
      repeat (12) add_seg(4, 4);
      en_range(2, wlen);
      build_model();
      run_scenario(63);

      // restart after reset: first result only after arm plus a full period
      do_reset();
      clear_wave();
      add_seg(0, 3);
      repeat (7) add_seg(3, 4);
      en_range(1, wlen);
      build_model();
      run_scenario(-1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
